// File: rtl/bp_be_thread_ctxt_ctrl.sv
// Backend context-switch sequencer.
// A CTXT CSR write to a different, implemented thread quiesces issue, waits
// for the pipeline to drain, saves the outgoing thread's next PC, swaps the
// active thread ID and offers the incoming thread's saved PC as a frontend
// redirect.
module bp_be_thread_ctxt_ctrl #(
  parameter int thread_id_width_p = 2,
  parameter int num_threads_p     = 4,
  parameter int vaddr_width_p     = 39,
  parameter logic [vaddr_width_p-1:0] reset_pc_p = 39'h0080000000
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         csr_ctxt_write_v_i,
  input  logic [thread_id_width_p-1:0] csr_ctxt_write_data_i,
  input  logic [vaddr_width_p-1:0]     retire_npc_i,
  input  logic                         pipe_empty_i,
  input  logic                         redirect_yumi_i,
  output logic [thread_id_width_p-1:0] current_thread_id_o,
  output logic                         suspend_o,
  output logic                         redirect_v_o,
  output logic [vaddr_width_p-1:0]     redirect_pc_o,
  output logic                         switch_done_o,
  output logic                         bad_target_o,
  output logic [15:0]                  switch_cnt_o
);

  // One extra bit so the implemented-thread count is representable even
  // when it equals 2**thread_id_width_p.
  localparam logic [thread_id_width_p:0] num_threads_lp =
    (thread_id_width_p+1)'(num_threads_p);

  typedef enum logic [1:0] {
    e_idle,
    e_drain,
    e_swap,
    e_redirect
  } state_e;

  state_e state_r, state_n;

  logic                         suspend_r;
  logic                         bad_target_r;
  logic                         accept_write;
  logic                         bad_write;
  logic [thread_id_width_p-1:0] current_r;
  logic [thread_id_width_p-1:0] target_r;
  logic [vaddr_width_p-1:0]     save_pc_r;
  logic [vaddr_width_p-1:0]     redir_pc_r;
  logic [15:0]                  switch_cnt_r;
  logic [vaddr_width_p-1:0]     pc_table_r [num_threads_p];

  logic [thread_id_width_p:0]   write_data_wide;
  assign write_data_wide = {1'b0, csr_ctxt_write_data_i};

  // Next-state logic plus the combinational handshake outputs.
  always_comb begin
    state_n       = state_r;
    accept_write  = 1'b0;
    bad_write     = 1'b0;
    redirect_v_o  = 1'b0;
    switch_done_o = 1'b0;
    case (state_r)
      e_idle: begin
        if (csr_ctxt_write_v_i) begin
          if (write_data_wide >= num_threads_lp) begin
            bad_write = 1'b1;
          end else if (csr_ctxt_write_data_i != current_r) begin
            accept_write = 1'b1;
            state_n      = e_drain;
          end
        end
      end
      e_drain: begin
        if (pipe_empty_i) begin
          state_n = e_swap;
        end
      end
      e_swap: begin
        state_n = e_redirect;
      end
      e_redirect: begin
        redirect_v_o = 1'b1;
        if (redirect_yumi_i) begin
          switch_done_o = 1'b1;
          state_n       = e_idle;
        end
      end
      default: begin
        state_n = e_idle;
      end
    endcase
  end

  // State register; suspend and the reject pulse are registered decodes.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= e_idle;
      suspend_r    <= 1'b0;
      bad_target_r <= 1'b0;
    end else begin
      state_r      <= state_n;
      suspend_r    <= (state_n != e_idle);
      bad_target_r <= bad_write;
    end
  end

  // Switch datapath: latch request, swap thread and fetch restore PC, count.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      target_r     <= '0;
      save_pc_r    <= reset_pc_p;
      redir_pc_r   <= reset_pc_p;
      current_r    <= '0;
      switch_cnt_r <= '0;
    end else begin
      if (accept_write) begin
        target_r  <= csr_ctxt_write_data_i;
        save_pc_r <= retire_npc_i;
      end
      if (state_r == e_swap) begin
        redir_pc_r <= pc_table_r[target_r];
        current_r  <= target_r;
      end
      if (switch_done_o) begin
        switch_cnt_r <= switch_cnt_r + 16'd1;
      end
    end
  end

  // Per-thread saved PC; the outgoing thread is written during SWAP. Target
  // and current differ there, so the read above always sees the old value.
  for (genvar gi = 0; gi < num_threads_p; gi++) begin : g_pc_table
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        pc_table_r[gi] <= reset_pc_p;
      end else if ((state_r == e_swap) &&
                   (current_r == thread_id_width_p'(gi))) begin
        pc_table_r[gi] <= save_pc_r;
      end
    end
  end

  assign current_thread_id_o = current_r;
  assign suspend_o           = suspend_r;
  assign redirect_pc_o       = redir_pc_r;
  assign bad_target_o        = bad_target_r;
  assign switch_cnt_o        = switch_cnt_r;

endmodule

// File: tb/tb_bp_be_thread_ctxt_ctrl.sv
// Scoreboard bench for the context-switch sequencer. Expected redirects are
// queued when a switch is requested and compared when the DUT offers them.
module tb_bp_be_thread_ctxt_ctrl;

  localparam logic [38:0] reset_pc_lp = 39'h0080000000;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b1;
  logic        csr_ctxt_write_v_i = 1'b0;
  logic [1:0]  csr_ctxt_write_data_i = '0;
  logic [38:0] retire_npc_i = '0;
  logic        pipe_empty_i = 1'b1;
  logic        redirect_yumi_i = 1'b0;
  logic [1:0]  current_thread_id_o;
  logic        suspend_o;
  logic        redirect_v_o;
  logic [38:0] redirect_pc_o;
  logic        switch_done_o;
  logic        bad_target_o;
  logic [15:0] switch_cnt_o;

  // Second instance with three implemented threads for the reject path.
  logic        b_write_v = 1'b0;
  logic [1:0]  b_write_data = '0;
  logic [1:0]  b_current;
  logic        b_suspend;
  logic        b_redirect_v;
  logic [38:0] b_redirect_pc;
  logic        b_done;
  logic        b_bad;
  logic [15:0] b_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [38:0] pc;
    logic [1:0]  tid;
  } exp_t;

  exp_t        exp_q[$];
  logic [38:0] model_pc [4];
  logic [1:0]  model_cur;
  logic [15:0] model_cnt;

  always #5 clk_i = ~clk_i;

  bp_be_thread_ctxt_ctrl #(
    .thread_id_width_p(2), .num_threads_p(4), .vaddr_width_p(39), .reset_pc_p(reset_pc_lp)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .csr_ctxt_write_v_i(csr_ctxt_write_v_i), .csr_ctxt_write_data_i(csr_ctxt_write_data_i),
    .retire_npc_i(retire_npc_i), .pipe_empty_i(pipe_empty_i), .redirect_yumi_i(redirect_yumi_i),
    .current_thread_id_o(current_thread_id_o), .suspend_o(suspend_o),
    .redirect_v_o(redirect_v_o), .redirect_pc_o(redirect_pc_o),
    .switch_done_o(switch_done_o), .bad_target_o(bad_target_o), .switch_cnt_o(switch_cnt_o)
  );

  bp_be_thread_ctxt_ctrl #(
    .thread_id_width_p(2), .num_threads_p(3), .vaddr_width_p(39), .reset_pc_p(reset_pc_lp)
  ) dut_b (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .csr_ctxt_write_v_i(b_write_v), .csr_ctxt_write_data_i(b_write_data),
    .retire_npc_i(retire_npc_i), .pipe_empty_i(pipe_empty_i), .redirect_yumi_i(1'b0),
    .current_thread_id_o(b_current), .suspend_o(b_suspend),
    .redirect_v_o(b_redirect_v), .redirect_pc_o(b_redirect_pc),
    .switch_done_o(b_done), .bad_target_o(b_bad), .switch_cnt_o(b_cnt)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) model_pc[i] = reset_pc_lp;
    model_cur = '0;
    model_cnt = '0;
    exp_q.delete();
  endtask

  // Request a switch; drain = cycles pipe_empty stays low in DRAIN,
  // hold = cycles yumi is withheld, inject = stray write during the hold.
  task automatic do_switch(input logic [1:0] tid, input logic [38:0] npc,
                           input int drain, input int hold, input bit inject);
    exp_t e;
    int   n;
    e.pc  = model_pc[tid];
    e.tid = tid;
    model_pc[model_cur] = npc;
    model_cur = tid;
    exp_q.push_back(e);
    csr_ctxt_write_v_i    = 1'b1;
    csr_ctxt_write_data_i = tid;
    retire_npc_i          = npc;
    @(negedge clk_i);
    csr_ctxt_write_v_i = 1'b0;
    n = 1;
    while (!redirect_v_o && n < 100) begin
      pipe_empty_i = (n > drain);
      check_val("suspend_wait", suspend_o, 1);
      @(negedge clk_i);
      n++;
    end
    pipe_empty_i = 1'b1;
    check_val("latency", n, 3 + drain);
    if (exp_q.size() == 0) begin
      check_val("sb_nonempty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check_val("redirect_pc", redirect_pc_o, e.pc);
      check_val("thread_at_redirect", current_thread_id_o, e.tid);
    end
    for (int j = 0; j < hold; j++) begin
      csr_ctxt_write_v_i    = inject && (j == 1);
      csr_ctxt_write_data_i = 2'd2;
      check_val("hold_v", redirect_v_o, 1);
      check_val("hold_pc", redirect_pc_o, e.pc);
      check_val("hold_done", switch_done_o, 0);
      @(negedge clk_i);
    end
    csr_ctxt_write_v_i = 1'b0;
    redirect_yumi_i = 1'b1;
    #1;
    check_val("done_pulse", switch_done_o, 1);
    @(negedge clk_i);
    redirect_yumi_i = 1'b0;
    model_cnt++;
    check_val("done_low", switch_done_o, 0);
    check_val("redirect_v_low", redirect_v_o, 0);
    check_val("suspend_idle", suspend_o, 0);
    check_val("switch_cnt", switch_cnt_o, model_cnt);
    check_val("thread_after", current_thread_id_o, tid);
    $display("switch to %0d npc=0x%0h: latency=%0d pc=0x%0h cnt=%0d",
             tid, npc, n, redirect_pc_o, switch_cnt_o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #2 reset_n_i = 1'b0;
    #1;
    check_val("rst_thread", current_thread_id_o, 0);
    check_val("rst_suspend", suspend_o, 0);
    check_val("rst_redirect_v", redirect_v_o, 0);
    check_val("rst_redirect_pc", redirect_pc_o, reset_pc_lp);
    check_val("rst_done", switch_done_o, 0);
    check_val("rst_bad", bad_target_o, 0);
    check_val("rst_cnt", switch_cnt_o, 0);
    $display("reset state checked");
    repeat (3) @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);

    // Basic switches and PC save/restore round trip.
    do_switch(2'd1, 39'h1000, 0, 0, 1'b0);
    do_switch(2'd0, 39'h2000, 0, 0, 1'b0);
    do_switch(2'd1, 39'h3000, 0, 0, 1'b0);
    // Slow drain and withheld yumi with a dropped write.
    do_switch(2'd0, 39'h4000, 5, 0, 1'b0);
    do_switch(2'd1, 39'h5000, 0, 4, 1'b1);
    repeat (2) @(negedge clk_i);
    check_val("dropped_write_thread", current_thread_id_o, 1);
    check_val("dropped_write_idle", suspend_o, 0);
    check_val("dropped_write_bad", bad_target_o, 0);
    $display("dropped write: thread=%0d suspend=%0d", current_thread_id_o, suspend_o);

    // Write to the current thread is a no-op; stray yumi is ignored.
    csr_ctxt_write_v_i    = 1'b1;
    csr_ctxt_write_data_i = 2'd1;
    redirect_yumi_i       = 1'b1;
    @(negedge clk_i);
    csr_ctxt_write_v_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_val("noop_suspend", suspend_o, 0);
      check_val("noop_bad", bad_target_o, 0);
      check_val("noop_cnt", switch_cnt_o, model_cnt);
      @(negedge clk_i);
    end
    redirect_yumi_i = 1'b0;
    $display("same-thread write: suspend=%0d cnt=%0d", suspend_o, switch_cnt_o);

    // Unimplemented target on the three-thread instance.
    b_write_v    = 1'b1;
    b_write_data = 2'd3;
    @(negedge clk_i);
    b_write_v = 1'b0;
    check_val("bad_pulse", b_bad, 1);
    check_val("bad_suspend", b_suspend, 0);
    check_val("bad_thread", b_current, 0);
    @(negedge clk_i);
    check_val("bad_pulse_end", b_bad, 0);
    check_val("bad_still_idle", b_suspend, 0);
    $display("bad target 3: pulse seen, instance idle");

    // Reset while draining aborts the switch.
    pipe_empty_i          = 1'b0;
    csr_ctxt_write_v_i    = 1'b1;
    csr_ctxt_write_data_i = 2'd2;
    retire_npc_i          = 39'h6000;
    @(negedge clk_i);
    csr_ctxt_write_v_i = 1'b0;
    @(negedge clk_i);
    check_val("pre_abort_suspend", suspend_o, 1);
    reset_n_i = 1'b0;
    #1;
    check_val("abort_thread", current_thread_id_o, 0);
    check_val("abort_suspend", suspend_o, 0);
    check_val("abort_redirect_v", redirect_v_o, 0);
    check_val("abort_redirect_pc", redirect_pc_o, reset_pc_lp);
    check_val("abort_cnt", switch_cnt_o, 0);
    model_reset();
    pipe_empty_i = 1'b1;
    $display("reset during drain: outputs at reset values");
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    do_switch(2'd1, 39'h7000, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bp_be_thread_ctxt_ctrl.md
# bp_be_thread_ctxt_ctrl

Backend context-switch sequencer downstream of the system pipe's CTXT CSR (0x081) write port. On a CTXT write it quiesces issue and waits for the pipeline to drain. It then saves the outgoing thread's next PC, swaps the active thread ID, and hands the incoming thread's saved PC to the frontend as a redirect. The `current_thread_id_o` output feeds back into the system pipe's `current_thread_id_i`.

## Interface
Parameters:
- `thread_id_width_p`, 2: width of thread ID.
- `num_threads_p`, 4: implemented threads, ≤ 2**`thread_id_width_p`.
- `vaddr_width_p`, 39: PC width.
- `reset_pc_p`, 39'h0080000000: initial PC of every thread.

Ports:
- `clk_i` in 1: clock; all state on rising edge.
- `reset_n_i` in 1: reset, asynchronous, active-low.
- `csr_ctxt_write_v_i` in 1: CTXT CSR write retired (one-cycle pulse).
- `csr_ctxt_write_data_i` in `thread_id_width_p`: target thread ID.
- `retire_npc_i` in `vaddr_width_p`: next PC of the retiring CTXT write; valid with `csr_ctxt_write_v_i`.
- `pipe_empty_i` in 1: no instructions in flight past issue.
- `redirect_yumi_i` in 1: frontend accepts redirect.
- `current_thread_id_o` out `thread_id_width_p`: active thread.
- `suspend_o` out 1: block issue.
- `redirect_v_o` out 1: redirect valid.
- `redirect_pc_o` out `vaddr_width_p`: restored PC of incoming thread.
- `switch_done_o` out 1: one-cycle pulse on redirect handshake.
- `bad_target_o` out 1: one-cycle pulse, write rejected.
- `switch_cnt_o` out 16: completed switches, wraps.

## Operation
- PC table: `num_threads_p` × `vaddr_width_p` registers. Reset value is `reset_pc_p`.
- Internal latches: `target_r`, `save_pc_r`, `redir_pc_r`.
- FSM states: IDLE, DRAIN, SWAP, REDIRECT.
- **IDLE, write received:**
  - If `data ≥ num_threads_p`: pulse `bad_target_o` next cycle; stay IDLE.
  - If `data == current_thread_id_o`: no-op; stay IDLE; no pulse; counter unchanged.
  - Otherwise: latch `target_r <= data` and `save_pc_r <= retire_npc_i`; go to DRAIN.
- **DRAIN:** hold until `pipe_empty_i == 1`, then go to SWAP. Waits indefinitely; there is no timeout.
- **SWAP (exactly one cycle):**
  - `pc_table[current] <= save_pc_r`.
  - `redir_pc_r <= pc_table[target_r]`, read before the write. The two indices always differ.
  - `current_thread_id_o <= target_r`.
  - Go to REDIRECT.
- **REDIRECT:** `redirect_v_o = 1`, `redirect_pc_o = redir_pc_r`; hold both stable until `redirect_yumi_i`. On yumi:
  - `switch_done_o = 1` in the same cycle (combinational).
  - `switch_cnt_o` increments, visible the next cycle.
  - Return to IDLE.
- `suspend_o = 1` in DRAIN, SWAP and REDIRECT; 0 in IDLE. It is a registered state decode.
- CTXT writes arriving in any non-IDLE state are dropped silently. `bad_target_o` is not pulsed for them.
- `redirect_yumi_i` outside REDIRECT is ignored.
- `pipe_empty_i` outside DRAIN is ignored.

## Timing
- Reset values (async, immediate on `reset_n_i` low):
  - state IDLE; `current_thread_id_o = 0`; `suspend_o = 0`; `redirect_v_o = 0`.
  - `redirect_pc_o = reset_pc_p`; `switch_done_o = 0`; `bad_target_o = 0`; `switch_cnt_o = 0`.
  - All table entries = `reset_pc_p`.
- Reset mid-switch aborts the switch fully. The thread returns to 0 and no save occurs.
- Cycle sequence, with write at cycle 0, `pipe_empty_i` already high and yumi on first offer:
  - DRAIN/`suspend_o` at cycle 1.
  - SWAP at cycle 2.
  - REDIRECT at cycle 3: `redirect_v_o` high and new `current_thread_id_o` visible.
  - yumi at cycle 3, IDLE at cycle 4.
- Minimum write→redirect latency is 3 cycles. Each cycle `pipe_empty_i` is low in DRAIN adds one cycle.
- `switch_cnt_o` wraps 16'hFFFF→0.
- Write and reset release in the same cycle: the write is ignored.

## Test plan
- Reset then write target 1, npc 0x1000, `pipe_empty_i = 1` → `redirect_v_o` at cycle 3 with pc 0x0080000000; `current_thread_id_o = 1`; `switch_cnt_o = 1`.
- Switch 0→1 (npc 0x1000), then 1→0 (npc 0x2000) → second redirect pc = 0x1000. Switch 0→1 again → pc = 0x2000.
- Hold `pipe_empty_i = 0` for 5 cycles in DRAIN → `suspend_o` high throughout; SWAP one cycle after empty rises; redirect latency 8.
- Withhold yumi 4 cycles → `redirect_v_o` and pc stable. A CTXT write to thread 2 during the wait is dropped; thread stays 1 after done.
- Write target = current → no suspend, no pulse, count unchanged.
- With `num_threads_p = 3`, write target 3 → `bad_target_o` pulse; state IDLE.
- Assert `reset_n_i` low in DRAIN → all outputs at reset values immediately; the next switch to 1 redirects to `reset_pc_p`.
